rgb2yuv_stream: RTL and testbench

Pipelined RGB888 to YUV444 converter that sits directly upstream of clahe_top in the video path. It converts each pixel to full-range BT.601 Y/U/V and delays href/vsync so the sync signals stay aligned with the data. It also checks frame geometry (pixels per line, lines per frame) and reports per-frame status. Its outputs connect to clahe_top in_y/in_u/in_v/in_href/in_vsync with no glue logic.

---
 rtl/rgb2yuv_stream_if.sv | 16 +
 rtl/rgb2yuv_stream.sv | 96 +++++++++
 tb/tb_rgb2yuv_stream.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/rgb2yuv_stream_if.sv
// rgb2yuv_stream_if: RGB pixel stream in, YUV stream and frame status out
interface rgb2yuv_stream_if #(parameter int CNT_W = 12);
  logic [7:0] in_r, in_g, in_b;
  logic in_href, in_vsync;
  logic [7:0] out_y, out_u, out_v;
  logic out_href, out_vsync, frame_done, line_err, frame_err;
  logic [CNT_W-1:0] last_lines;
  modport slave (
    input in_r, in_g, in_b, in_href, in_vsync,
    output out_y, out_u, out_v, out_href, out_vsync, frame_done, line_err, frame_err, last_lines
  );
  modport master (
    output in_r, in_g, in_b, in_href, in_vsync,
    input out_y, out_u, out_v, out_href, out_vsync, frame_done, line_err, frame_err, last_lines
  );
endinterface

// File: rtl/rgb2yuv_stream.sv
// rgb2yuv_stream: 3-stage RGB888 to full-range BT.601 YUV444 converter with aligned syncs and frame geometry checks
module rgb2yuv_stream #(
  parameter int H_DISP = 1280,
  parameter int V_DISP = 720,
  parameter int CNT_W = 12
) (
  input logic pclk,
  input logic rst_n,
  rgb2yuv_stream_if.slave s
);
  localparam logic [1:0] IDLE = 2'd0, ACTIVE = 2'd1, DONE = 2'd2;
  localparam logic signed [25:0] K [9] = '{
    26'sd19595, 26'sd38470, 26'sd7471,
    -26'sd11059, -26'sd21709, 26'sd32768,
    26'sd32768, -26'sd27439, -26'sd5329
  };
  logic signed [25:0] p_d [9], p_q [9];
  logic signed [26:0] sum_d [3], sum_q [3];
  logic signed [11:0] t [3];
  logic [7:0] c_d [3], c_q [3];
  logic [2:0] href_q, vs_q;
  logic [CNT_W-1:0] pix_d, pix_q, line_d, line_q, lines1_q, last_lines_q;
  logic [1:0] state_d, state_q;
  logic lerr_d, lerr_q, armed_q, done1_q, lerr1_q, frame_done_q, line_err_q, frame_err_q;
  logic href_fall, line_end, vs_rise, vs_fall;
  for (genvar i = 0; i < 9; i++) begin : g_prod
    assign p_d[i] = $signed({18'd0, (i % 3 == 0) ? s.in_r : (i % 3 == 1) ? s.in_g : s.in_b}) * K[i];
  end
  for (genvar k = 0; k < 3; k++) begin : g_ch
    assign sum_d[k] = 27'sd32768 + 27'(p_q[3*k]) + 27'(p_q[3*k+1]) + 27'(p_q[3*k+2]);
    assign t[k] = 12'(sum_q[k] >>> 16) + ((k == 0) ? 12'sd0 : 12'sd128);
    assign c_d[k] = t[k][11] ? 8'd0 : (|t[k][10:8]) ? 8'd255 : t[k][7:0];
  end
  assign href_fall = href_q[0] & ~s.in_href;
  assign line_end = href_fall & vs_q[0];
  assign vs_rise = s.in_vsync & ~vs_q[0] & armed_q;
  assign vs_fall = ~s.in_vsync & vs_q[0];
  always_comb begin
    pix_d = (vs_rise | href_fall) ? '0 : (s.in_href & s.in_vsync & ~&pix_q) ? pix_q + 1'b1 : pix_q;
    line_d = vs_rise ? '0 : (line_end & ~&line_q) ? line_q + 1'b1 : line_q;
    lerr_d = ~vs_rise & (lerr_q | (line_end & (pix_q != CNT_W'(H_DISP))));
    state_d = (state_q == IDLE) ? (vs_rise ? ACTIVE : IDLE) :
              (state_q == ACTIVE) ? (vs_fall ? DONE : ACTIVE) : IDLE;
  end
  always_ff @(posedge pclk or negedge rst_n)
    if (!rst_n) begin
      p_q <= '{default: '0};
      sum_q <= '{default: '0};
      c_q <= '{default: '0};
      href_q <= '0;
      vs_q <= '0;
      pix_q <= '0;
      line_q <= '0;
      lerr_q <= 1'b0;
      armed_q <= 1'b0;
      state_q <= IDLE;
      done1_q <= 1'b0;
      lines1_q <= '0;
      lerr1_q <= 1'b0;
      frame_done_q <= 1'b0;
      last_lines_q <= '0;
      frame_err_q <= 1'b0;
      line_err_q <= 1'b0;
    end else begin
      p_q <= p_d;
      sum_q <= sum_d;
      for (int i = 0; i < 3; i++) c_q[i] <= href_q[1] ? c_d[i] : 8'd0;
      href_q <= {href_q[1:0], s.in_href};
      vs_q <= {vs_q[1:0], s.in_vsync};
      pix_q <= pix_d;
      line_q <= line_d;
      lerr_q <= lerr_d;
      armed_q <= armed_q | ~s.in_vsync;
      state_q <= state_d;
      done1_q <= state_q == DONE;
      if (state_q == DONE) begin
        lines1_q <= line_q;
        lerr1_q <= lerr_q;
      end
      frame_done_q <= done1_q;
      if (done1_q) begin
        last_lines_q <= lines1_q;
        frame_err_q <= lines1_q != CNT_W'(V_DISP);
        line_err_q <= lerr1_q;
      end
    end
  assign s.out_y = c_q[0];
  assign s.out_u = c_q[1];
  assign s.out_v = c_q[2];
  assign s.out_href = href_q[2];
  assign s.out_vsync = vs_q[2];
  assign s.frame_done = frame_done_q;
  assign s.line_err = line_err_q;
  assign s.frame_err = frame_err_q;
  assign s.last_lines = last_lines_q;
endmodule

// File: tb/tb_rgb2yuv_stream.sv
// tb_rgb2yuv_stream: randomized frames against an arithmetic YUV and frame-geometry model via a scoreboard
module tb_rgb2yuv_stream;
  localparam int H = 16, V = 8, CW = 8;
  typedef struct { int due; logic [1:0] sync; logic [7:0] y, u, v; } px_t;
  typedef struct { int due; int lines; bit ferr, lerr; } fd_t;
  logic pclk = 1'b0;
  logic rst_n = 1'b0;
  int cyc = 0;
  int n_chk = 0, n_fail = 0;
  bit rst_hist [0:8191];
  px_t pq[$];
  fd_t fq[$];
  bit m_frame, m_seen, m_ph, m_pv, m_lerr;
  int m_pix, m_lines;
  px_t me;
  fd_t mf;
  bit fd_now, st_ferr, st_lerr;
  int st_lines;
  rgb2yuv_stream_if #(.CNT_W(CW)) bus();
  rgb2yuv_stream #(.H_DISP(H), .V_DISP(V), .CNT_W(CW)) dut (.pclk(pclk), .rst_n(rst_n), .s(bus));
  always #5 pclk = ~pclk;
  always @(posedge pclk) cyc <= cyc + 1;
  function automatic void check(string nm, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endfunction
  function automatic logic [7:0] clip(int x);
    return x < 0 ? 8'd0 : x > 255 ? 8'd255 : x[7:0];
  endfunction
  task automatic drive(bit rst, bit h, bit v, logic [7:0] r, logic [7:0] g, logic [7:0] b,
                       bit ov = 1'b0, logic [23:0] yuv = 24'd0);
    px_t e;
    fd_t f;
    int ri, gi, bi;
    ri = r; gi = g; bi = b;
    @(negedge pclk);
    #1;
    rst_n = rst;
    bus.in_href = h;
    bus.in_vsync = v;
    bus.in_r = r;
    bus.in_g = g;
    bus.in_b = b;
    rst_hist[cyc] = rst;
    e.due = cyc + 3;
    e.sync = {h, v};
    e.y = h ? clip((19595*ri + 38470*gi + 7471*bi + 32768) >>> 16) : 8'd0;
    e.u = h ? clip(((-11059*ri - 21709*gi + 32768*bi + 32768) >>> 16) + 128) : 8'd0;
    e.v = h ? clip(((32768*ri - 27439*gi - 5329*bi + 32768) >>> 16) + 128) : 8'd0;
    if (ov) {e.y, e.u, e.v} = yuv;
    pq.push_back(e);
    if (!rst) begin
      {m_frame, m_seen, m_ph, m_pv, m_lerr} = '0;
      m_pix = 0;
      m_lines = 0;
    end else begin
      if (m_ph && !h && m_pv) begin
        m_lines++;
        if (m_pix != H) m_lerr = 1'b1;
      end
      if (m_ph && !h) m_pix = 0;
      if (m_frame && m_pv && !v) begin
        f.due = cyc + 3;
        f.lines = m_lines;
        f.ferr = m_lines != V;
        f.lerr = m_lerr;
        fq.push_back(f);
        m_frame = 1'b0;
      end
      if (!m_frame && v && !m_pv && m_seen) begin
        m_frame = 1'b1;
        m_lines = 0;
        m_lerr = 1'b0;
        m_pix = 0;
      end
      if (h && v) m_pix++;
      if (!v) m_seen = 1'b1;
      m_ph = h;
      m_pv = v;
    end
  endtask
  task automatic rnd(bit rst, bit h, bit v);
    drive(rst, h, v, 8'($urandom), 8'($urandom), 8'($urandom));
  endtask
  task automatic frame(int nl, int short_line, int rst_line, bit simul);
    repeat (3) rnd(1, 0, 1);
    for (int l = 0; l < nl; l++) begin
      for (int p = 0; p < ((l == short_line) ? H - 1 : H); p++) begin
        if (l == rst_line && p == H / 2) repeat (3) rnd(0, 1, 1);
        if ($urandom_range(0, 4) == 0) rnd(1, 0, 1);
        rnd(1, 1, 1);
      end
      if (!(simul && l == nl - 1)) repeat (2) rnd(1, 0, 1);
    end
    repeat (8) rnd(1, 0, 0);
  endtask
  always @(negedge pclk) begin
    if (!rst_n) begin
      check("reset_outputs", {bus.out_y, bus.out_u, bus.out_v, bus.out_href, bus.out_vsync,
                              bus.frame_done, bus.line_err, bus.frame_err, bus.last_lines}, 64'd0);
      st_lines = 0;
      st_ferr = 1'b0;
      st_lerr = 1'b0;
    end
    if (pq.size() > 0 && pq[0].due == cyc) begin
      me = pq.pop_front();
      if (!(rst_hist[me.due-3] && rst_hist[me.due-2] && rst_hist[me.due-1])) begin
        me.sync = 2'b00;
        {me.y, me.u, me.v} = 24'd0;
      end
      check("pixel", {bus.out_href, bus.out_vsync, bus.out_y, bus.out_u, bus.out_v},
                     {me.sync, me.y, me.u, me.v});
    end
    fd_now = fq.size() > 0 && fq[0].due == cyc;
    if (fd_now) begin
      mf = fq.pop_front();
      st_lines = mf.lines;
      st_ferr = mf.ferr;
      st_lerr = mf.lerr;
    end
    check("status", {bus.frame_done, bus.line_err, bus.frame_err, bus.last_lines},
                    {fd_now, st_lerr, st_ferr, CW'(st_lines)});
  end
  initial begin
    {bus.in_r, bus.in_g, bus.in_b, bus.in_href, bus.in_vsync} = '0;
    repeat (4) rnd(0, 0, 0);
    repeat (3) rnd(1, 0, 0);
    drive(1, 1, 0, 8'd255, 8'd255, 8'd255, 1'b1, {8'd255, 8'd128, 8'd128});
    repeat (2) rnd(1, 0, 0);
    drive(1, 1, 0, 8'd255, 8'd0, 8'd0, 1'b1, {8'd76, 8'd85, 8'd255});
    rnd(1, 0, 0);
    drive(1, 1, 0, 8'd0, 8'd0, 8'd255, 1'b1, {8'd29, 8'd255, 8'd107});
    drive(1, 1, 0, 8'd0, 8'd0, 8'd0, 1'b1, {8'd0, 8'd128, 8'd128});
    repeat (3) rnd(1, 0, 0);
    frame(V, -1, -1, 1'b0);
    frame(V - 1, 5, -1, 1'b0);
    frame(V, -1, -1, 1'b1);
    frame(V, -1, 3, 1'b0);
    frame(V, -1, -1, 1'b0);
    repeat (6) rnd(1, 0, 0);
    repeat (5) @(negedge pclk);
    #1;
    check("pixel_queue_drained", 64'(pq.size()), 64'd0);
    check("frame_done_queue_drained", 64'(fq.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
